score_digits_driver: RTL and testbench

- Drives the digit-glyph renderer for a multi-digit decimal score field.
- Converts a binary score to BCD with a sequential double-dabble engine and holds the result in a display register.
- For each scanned pixel, produces the renderer's inputs: glyph code, in-glyph X/Y offset and inside-cell flag.
- Sits between the game-logic score counter and the glyph renderer, ahead of the colour mux.

---
 rtl/score_pkg.sv | 16 +
 rtl/bcd_dabble_step.sv | 37 +++
 rtl/score_digits_driver.sv | 166 ++++++++++++++++
 tb/tb_score_digits_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score digit driver.
package score_pkg;

   // Conversion sequencer states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } score_state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
   localparam bcd_digit_t ADD3_THRESHOLD = 4'd5;

endpackage : score_pkg

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add-3 correction on every BCD nibble, then
// shift {bcd, bin} left by one bit.
module bcd_dabble_step
   import score_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCORE_W    = 14
) (
   input  logic [4*NUM_DIGITS-1:0] i_bcd,
   input  logic [SCORE_W-1:0]      i_bin,
   output logic [4*NUM_DIGITS-1:0] o_bcd,
   output logic [SCORE_W-1:0]      o_bin
);

   localparam int unsigned BCD_W = 4 * NUM_DIGITS;

   logic [BCD_W-1:0] w_adj;

   // Correct each nibble that would overflow past 9 once doubled
   always_comb begin
      w_adj = i_bcd;
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         bcd_digit_t v_nib;
         v_nib = i_bcd[4*k +: 4];
         if (v_nib >= ADD3_THRESHOLD) begin
            w_adj[4*k +: 4] = v_nib + 4'd3;
         end
      end
   end

   // Shift the corrected accumulator and the binary remainder as one word
   always_comb begin
      o_bcd = {w_adj[BCD_W-2:0], i_bin[SCORE_W-1]};
      o_bin = {i_bin[SCORE_W-2:0], 1'b0};
   end

endmodule : bcd_dabble_step

// File: rtl/score_digits_driver.sv
// Score field driver: converts a binary score to BCD and, per scanned pixel,
// produces glyph code, in-cell offsets and the visible-cell flag.
module score_digits_driver
   import score_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4,
   parameter int unsigned SCORE_W    = 14,
   parameter int unsigned DIGIT_W    = 16,
   parameter int unsigned DIGIT_H    = 32,
   parameter int unsigned DIGIT_GAP  = 2,
   parameter logic [10:0] TOP_LEFT_X = 11'd20,
   parameter logic [10:0] TOP_LEFT_Y = 11'd8,
   parameter bit          BLANK_LEAD = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score,
   input  logic               score_valid,
   input  logic [10:0]        pixelX,
   input  logic [10:0]        pixelY,
   output logic               busy,
   output logic [3:0]         number,
   output logic [10:0]        offsetX,
   output logic [10:0]        offsetY,
   output logic               insideRectangle
);

   localparam int unsigned BCD_W     = 4 * NUM_DIGITS;
   localparam int unsigned CNT_W     = $clog2(SCORE_W + 1);
   localparam int unsigned MAX_SCORE = 10**NUM_DIGITS - 1;
   localparam int unsigned CELL_PITCH = DIGIT_W + DIGIT_GAP;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SCORE_W - 1);

   score_state_e       r_state;
   logic               r_busy;
   logic [BCD_W-1:0]   r_bcd_acc;
   logic [SCORE_W-1:0] r_bin;
   logic [CNT_W-1:0]   r_bit_cnt;
   logic [BCD_W-1:0]   r_display;
   logic               r_pend_flag;
   logic [SCORE_W-1:0] r_pend_score;

   logic [SCORE_W-1:0] w_clamped;
   logic [BCD_W-1:0]   w_step_bcd;
   logic [SCORE_W-1:0] w_step_bin;

   // Saturate out-of-range scores to all nines before they are stored
   assign w_clamped = (32'(score) > MAX_SCORE) ? SCORE_W'(MAX_SCORE) : score;

   bcd_dabble_step #(
      .NUM_DIGITS (NUM_DIGITS),
      .SCORE_W    (SCORE_W)
   ) u_step (
      .i_bcd (r_bcd_acc),
      .i_bin (r_bin),
      .o_bcd (w_step_bcd),
      .o_bin (w_step_bin)
   );

   // Conversion sequencer with a one-deep, latest-wins pending slot
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_bcd_acc    <= '0;
         r_bin        <= '0;
         r_bit_cnt    <= '0;
         r_display    <= '0;
         r_pend_flag  <= 1'b0;
         r_pend_score <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (score_valid) begin
                  r_bin     <= w_clamped;
                  r_bcd_acc <= '0;
                  r_bit_cnt <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= CONVERT;
               end
            end
            CONVERT: begin
               r_bcd_acc <= w_step_bcd;
               r_bin     <= w_step_bin;
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == LAST_STEP) begin
                  r_state <= COMMIT;
               end
               if (score_valid) begin
                  r_pend_score <= w_clamped;
                  r_pend_flag  <= 1'b1;
               end
            end
            COMMIT: begin
               r_display <= r_bcd_acc;
               // A strobe landing here is newer than any stored pending score
               if (score_valid || r_pend_flag) begin
                  r_bin       <= score_valid ? w_clamped : r_pend_score;
                  r_pend_flag <= 1'b0;
                  r_bcd_acc   <= '0;
                  r_bit_cnt   <= '0;
                  r_state     <= CONVERT;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   logic        w_hit;
   logic [3:0]  w_number;
   logic [10:0] w_offset_x;
   logic [10:0] w_offset_y;
   logic        w_y_in;

   // Parallel cell compares with leading-zero blanking
   always_comb begin
      logic        v_lead_zero;
      logic        v_blank;
      logic [10:0] v_left;
      bcd_digit_t  v_digit;
      w_hit       = 1'b0;
      w_number    = 4'd0;
      w_offset_x  = 11'd0;
      w_offset_y  = 11'd0;
      v_lead_zero = 1'b1;
      w_y_in      = (pixelY >= TOP_LEFT_Y) && (pixelY <= TOP_LEFT_Y + 11'(DIGIT_H - 1));
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
         v_left      = TOP_LEFT_X + 11'(k * int'(CELL_PITCH));
         v_digit     = r_display[4*(int'(NUM_DIGITS) - 1 - k) +: 4];
         v_lead_zero = v_lead_zero && (v_digit == 4'd0);
         v_blank     = BLANK_LEAD && v_lead_zero && (k != int'(NUM_DIGITS) - 1);
         if (w_y_in && (pixelX >= v_left) && (pixelX <= v_left + 11'(DIGIT_W - 1))
             && !v_blank) begin
            w_hit      = 1'b1;
            w_number   = v_digit;
            w_offset_x = pixelX - v_left;
            w_offset_y = pixelY - TOP_LEFT_Y;
         end
      end
   end

   // Register the pixel-path results for the renderer
   always_ff @(posedge clk) begin
      if (reset) begin
         insideRectangle <= 1'b0;
         number          <= 4'd0;
         offsetX         <= 11'd0;
         offsetY         <= 11'd0;
      end else begin
         insideRectangle <= w_hit;
         number          <= w_number;
         offsetX         <= w_offset_x;
         offsetY         <= w_offset_y;
      end
   end

   assign busy = r_busy;

endmodule : score_digits_driver

// File: tb/tb_score_digits_driver.sv
// Self-checking bench for score_digits_driver against a time-based model.
module tb_score_digits_driver;

   logic        clk;
   logic        reset;
   logic [13:0] score;
   logic        score_valid;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic        busy;
   logic [3:0]  number;
   logic [10:0] offsetX;
   logic [10:0] offsetY;
   logic        insideRectangle;

   int n_checks = 0;
   int n_errors = 0;

   score_digits_driver dut (
      .clk             (clk),
      .reset           (reset),
      .score           (score),
      .score_valid     (score_valid),
      .pixelX          (pixelX),
      .pixelY          (pixelY),
      .busy            (busy),
      .number          (number),
      .offsetX         (offsetX),
      .offsetY         (offsetY),
      .insideRectangle (insideRectangle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: display value as an integer, conversion timed by cycle number
   int cyc = 0;
   bit m_active = 0;
   int m_commit = 0;
   int m_conv = 0;
   bit m_pend = 0;
   int m_pend_val = 0;
   int m_disp = 0;
   bit e_busy, e_in;
   int e_num, e_ox, e_oy;

   function automatic int pow10(input int e);
      int r = 1;
      for (int i = 0; i < e; i++) r = r * 10;
      return r;
   endfunction

   function automatic int clampv(input int s);
      return (s > 9999) ? 9999 : s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Expected outputs after the coming clock edge for the given inputs
   task automatic model_edge(input bit rst, input bit sv, input int sc, input int px, input int py);
      int rel, k, w;
      e_in = 0; e_num = 0; e_ox = 0; e_oy = 0;
      if (!rst && py >= 8 && py <= 39 && px >= 20) begin
         rel = px - 20;
         k   = rel / 18;
         w   = rel % 18;
         if (k < 4 && w < 16 && !(k < 3 && m_disp < pow10(3 - k))) begin
            e_in  = 1;
            e_num = (m_disp / pow10(3 - k)) % 10;
            e_ox  = w;
            e_oy  = py - 8;
         end
      end
      if (rst) begin
         m_active = 0; m_pend = 0; m_disp = 0;
      end else if (m_active && cyc == m_commit) begin
         m_disp = m_conv;
         if (sv) begin
            m_conv = clampv(sc); m_pend = 0; m_commit = cyc + 15;
         end else if (m_pend) begin
            m_conv = m_pend_val; m_pend = 0; m_commit = cyc + 15;
         end else begin
            m_active = 0;
         end
      end else if (m_active) begin
         if (sv) begin
            m_pend = 1; m_pend_val = clampv(sc);
         end
      end else if (sv) begin
         m_active = 1; m_conv = clampv(sc); m_commit = cyc + 15;
      end
      e_busy = m_active;
      cyc++;
   endtask

   // One cycle: drive at negedge, clock, then compare all outputs at next negedge
   task automatic tick(input bit rst, input bit sv, input int sc, input int px, input int py);
      reset       = rst;
      score_valid = sv;
      score       = 14'(sc);
      pixelX      = 11'(px);
      pixelY      = 11'(py);
      model_edge(rst, sv, sc, px, py);
      @(posedge clk);
      @(negedge clk);
      check("busy", int'(busy), int'(e_busy));
      check("insideRectangle", int'(insideRectangle), int'(e_in));
      check("number", int'(number), e_num);
      check("offsetX", int'(offsetX), e_ox);
      check("offsetY", int'(offsetY), e_oy);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         tick(0, 0, 0, 0, 0);
         n++;
      end
      check("idle_timeout", int'(busy), 0);
   endtask

   task automatic load_and_wait(input int sc);
      tick(0, 1, sc, 0, 0);
      wait_idle();
   endtask

   initial begin
      int n, hits, lo, hi;
      reset = 1; score_valid = 0; score = '0; pixelX = '0; pixelY = '0;
      @(negedge clk);
      tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      check("reset_busy", int'(busy), 0);
      check("reset_inside", int'(insideRectangle), 0);

      // Reset scan: only the last cell is visible, showing 0
      hits = 0; lo = 2047; hi = 0;
      for (int x = 0; x < 100; x++) begin
         tick(0, 0, 0, x, 20);
         if (insideRectangle) begin
            hits++;
            if (x < lo) lo = x;
            if (x > hi) hi = x;
         end
      end
      check("reset_scan_hits", hits, 16);
      check("reset_scan_lo", lo, 74);
      check("reset_scan_hi", hi, 89);
      tick(0, 0, 0, 89, 39);
      check("reset_cell3_ox", int'(offsetX), 15);
      check("reset_cell3_oy", int'(offsetY), 31);
      check("reset_cell3_num", int'(number), 0);
      tick(0, 0, 0, 80, 40);
      check("below_field", int'(insideRectangle), 0);

      // 1234: busy for exactly 15 cycles, then digit 1 reads 2
      tick(0, 1, 1234, 0, 0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         n++;
         tick(0, 0, 0, 0, 0);
      end
      check("busy_len_1234", n, 15);
      tick(0, 0, 0, 43, 15);
      check("d1_num_1234", int'(number), 2);
      check("d1_ox_1234", int'(offsetX), 5);
      check("d1_oy_1234", int'(offsetY), 7);
      check("d1_in_1234", int'(insideRectangle), 1);
      tick(0, 0, 0, 36, 15);
      check("gap_pixel", int'(insideRectangle), 0);

      // Saturation
      load_and_wait(16383);
      for (int k = 0; k < 4; k++) begin
         tick(0, 0, 0, 21 + 18 * k, 10);
         check("sat_digit", int'(number), 9);
      end

      // Leading-zero blanking
      load_and_wait(7);
      for (int k = 0; k < 3; k++) begin
         tick(0, 0, 0, 21 + 18 * k, 10);
         check("blank_lead", int'(insideRectangle), 0);
      end
      tick(0, 0, 0, 75, 10);
      check("last_digit_7", int'(number), 7);

      // Pending: 100 then 200, 300 while busy; latest wins, busy continuous
      n = 0;
      tick(0, 1, 100, 0, 0);
      for (int i = 1; i < 60; i++) begin
         if (busy) n++;
         if (i == 3) tick(0, 1, 200, 0, 0);
         else if (i == 10) tick(0, 1, 300, 0, 0);
         else tick(0, 0, 0, 40 + i, 20);
      end
      check("busy_len_pending", n, 30);
      tick(0, 0, 0, 21, 10);
      check("p_d0_blank", int'(insideRectangle), 0);
      tick(0, 0, 0, 39, 10);
      check("p_d1", int'(number), 3);
      tick(0, 0, 0, 57, 10);
      check("p_d2", int'(number), 0);
      check("p_d2_in", int'(insideRectangle), 1);

      // Reset mid-conversion
      tick(0, 1, 5000, 0, 0);
      for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0);
      check("rst_mid_busy", int'(busy), 0);
      tick(0, 0, 0, 75, 10);
      check("rst_mid_num", int'(number), 0);
      check("rst_mid_in", int'(insideRectangle), 1);
      tick(0, 0, 0, 39, 10);
      check("rst_mid_d1", int'(insideRectangle), 0);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 16383)), int'($urandom_range(0, 110)),
              int'($urandom_range(0, 45)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_score_digits_driver
